// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin arbiter and sequencer in front of a
// single-port word RAM (synchronous write, combinational read).
//
// Each access takes two cycles: the grant edge captures the winner's request into
// registers that drive the RAM; the following edge commits a write or returns
// registered read data with a one-cycle valid pulse.
//
// Ports:
//   i_clk, i_rst_n               clock (rising edge), asynchronous active-low reset
//   i_reqN/i_weN/i_addrN/i_wdataN  requester N access request, direction, address, data
//   o_gntN                       one-cycle grant pulse for requester N
//   o_rvalidN/o_rdataN           one-cycle read-valid pulse, held read data
//   o_ram_addr/o_ram_data        RAM address and write data
//   o_ram_MemWrite/o_ram_MemRead RAM write / read enables (never both high)
//   i_ram_data                   RAM read data
//   o_busy                       high while an access is in progress
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_MemWrite,
  output logic                  o_ram_MemRead,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_busy
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  last_q, last_d;     // requester served most recently
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;
  logic                  win;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = ram_we_q;
    ram_re_d   = ram_re_q;
    // On conflict the requester not served last wins; otherwise the lone requester.
    win        = (i_req0 && i_req1) ? ~last_q : i_req1;

    case (state_q)
      StIdle: begin
        if (i_req0 || i_req1) begin
          gnt0_d     = ~win;
          gnt1_d     = win;
          ram_addr_d = win ? i_addr1 : i_addr0;
          ram_data_d = win ? i_wdata1 : i_wdata0;
          ram_we_d   = win ? i_we1 : i_we0;
          ram_re_d   = win ? ~i_we1 : ~i_we0;
          last_d     = win;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        // The grant flag still identifies who owns this access.
        if (ram_re_q) begin
          if (gnt1_q) begin
            rdata1_d  = i_ram_data;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = i_ram_data;
            rvalid0_d = 1'b1;
          end
        end
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        ram_we_d = 1'b0;
        ram_re_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
    end
  end

  assign o_gnt0         = gnt0_q;
  assign o_gnt1         = gnt1_q;
  assign o_rvalid0      = rvalid0_q;
  assign o_rvalid1      = rvalid1_q;
  assign o_rdata0       = rdata0_q;
  assign o_rdata1       = rdata1_q;
  assign o_ram_addr     = ram_addr_q;
  assign o_ram_data     = ram_data_q;
  assign o_ram_MemWrite = ram_we_q;
  assign o_ram_MemRead  = ram_re_q;
  assign o_busy         = (state_q == StAccess);

endmodule
